// File: rtl/pixel_stream_processor_if.sv
// Pixel stream and register-bus bundle for pixel_stream_processor.
// The master side is the producer/consumer/configurator; the slave side is the processor.
interface pixel_stream_processor_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [OUT_WIDTH-1:0]  out_pixel;
    logic                  out_ready;
    logic                  frame_done;
    logic                  reg_write_en;
    logic [4:0]            reg_addr;
    logic [7:0]            reg_wdata;
    logic [7:0]            reg_rdata;

    modport master (
        output in_valid, in_data, out_ready, reg_write_en, reg_addr, reg_wdata,
        input  in_ready, out_valid, out_pixel, frame_done, reg_rdata
    );

    modport slave (
        input  in_valid, in_data, out_ready, reg_write_en, reg_addr, reg_wdata,
        output in_ready, out_valid, out_pixel, frame_done, reg_rdata
    );
endinterface

// File: rtl/pixel_stream_processor.sv
// Streaming pixel processor: pass-through, invert, threshold and 3x3 convolution.
// Define PIXEL_PROC_SAT_EN to clamp convolution results to the pixel range.
module pixel_stream_processor #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    pixel_stream_processor_if.slave  bus
);
    localparam int SUM_W = DATA_WIDTH + 12;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;
    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_THR  = 2'd2;
    localparam logic [1:0] MODE_CONV = 2'd3;

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [7:0]            r_frameCnt;
    logic [1:0]            r_shadowMode;
    logic [1:0]            r_activeMode;
    logic [7:0]            r_thr;
    logic [7:0]            r_kernel [0:8];
    logic                  r_outValid;
    logic [OUT_WIDTH-1:0]  r_outPixel;
    logic                  r_frameDone;
    logic [DATA_WIDTH-1:0] r_lb0 [0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] r_lb1 [0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] r_win [0:8];

    logic                  w_inReady;
    logic                  w_accept;
    logic                  w_colLast;
    logic                  w_rowLast;
    logic                  w_frameLast;
    logic                  w_produce;
    logic                  w_isKernel;
    logic [3:0]            w_kIdx;
    logic [DATA_WIDTH-1:0] w_nextWin [0:8];
    logic signed [SUM_W-1:0] w_sum;
    logic [OUT_WIDTH-1:0]  w_convWord;
    logic [OUT_WIDTH-1:0]  w_result;
    logic [7:0]            w_rdata;

    assign w_inReady   = !r_outValid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_inReady;
    assign w_colLast   = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_rowLast   = (r_row == ROW_W'(IMG_HEIGHT - 1));
    assign w_frameLast = w_colLast && w_rowLast;
    assign w_isKernel  = (bus.reg_addr >= 5'h04) && (bus.reg_addr <= 5'h0C);
    assign w_kIdx      = 4'(bus.reg_addr - 5'h04);
    assign w_produce   = (r_activeMode != MODE_CONV) ||
                         ((r_row >= ROW_W'(2)) && (r_col >= COL_W'(2)));

    // Window as it will look after this accept's shift, so the result uses the current pixel.
    always_comb begin
        w_nextWin[0] = r_win[1];
        w_nextWin[1] = r_win[2];
        w_nextWin[2] = r_lb1[r_col];
        w_nextWin[3] = r_win[4];
        w_nextWin[4] = r_win[5];
        w_nextWin[5] = r_lb0[r_col];
        w_nextWin[6] = r_win[7];
        w_nextWin[7] = r_win[8];
        w_nextWin[8] = bus.in_data;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) begin
            w_sum = w_sum + ($signed({{(SUM_W-DATA_WIDTH){1'b0}}, w_nextWin[i]}) *
                             $signed({{(SUM_W-8){r_kernel[i][7]}}, r_kernel[i]}));
        end
    end

`ifdef PIXEL_PROC_SAT_EN
    always_comb begin
        w_convWord = '0;
        if (w_sum[SUM_W-1])
            w_convWord = '0;
        else if (|w_sum[SUM_W-2:DATA_WIDTH])
            w_convWord = OUT_WIDTH'(PIX_MAX);
        else
            w_convWord = OUT_WIDTH'(w_sum[DATA_WIDTH-1:0]);
    end
`else
    assign w_convWord = OUT_WIDTH'(w_sum);
`endif

    always_comb begin
        w_result = '0;
        case (r_activeMode)
            MODE_PASS: w_result = OUT_WIDTH'(bus.in_data);
            MODE_INV:  w_result = OUT_WIDTH'(PIX_MAX - bus.in_data);
            MODE_THR:  w_result = (bus.in_data >= r_thr[DATA_WIDTH-1:0]) ? OUT_WIDTH'(PIX_MAX) : '0;
            default:   w_result = w_convWord;
        endcase
    end

    // Position counters, frame counter and frame-boundary mode switch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frameCnt   <= '0;
            r_activeMode <= MODE_PASS;
            r_frameDone  <= 1'b0;
        end else begin
            r_frameDone <= w_accept && w_frameLast;
            if (w_accept) begin
                if (w_colLast) begin
                    r_col <= '0;
                    r_row <= w_rowLast ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_frameLast) begin
                    r_frameCnt   <= r_frameCnt + 8'd1;
                    r_activeMode <= r_shadowMode;
                end
            end else if ((r_row == '0) && (r_col == '0)) begin
                r_activeMode <= r_shadowMode;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shadowMode <= MODE_PASS;
            r_thr        <= 8'h80;
            for (int i = 0; i < 9; i++) r_kernel[i] <= (i == 4) ? 8'd1 : 8'd0;
        end else if (bus.reg_write_en) begin
            if (bus.reg_addr == 5'h00)
                r_shadowMode <= bus.reg_wdata[1:0];
            else if (bus.reg_addr == 5'h01)
                r_thr <= bus.reg_wdata;
            else if (w_isKernel)
                r_kernel[w_kIdx] <= bus.reg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outValid <= 1'b0;
            r_outPixel <= '0;
        end else if (w_accept && w_produce) begin
            r_outValid <= 1'b1;
            r_outPixel <= w_result;
        end else if (bus.out_ready && r_outValid) begin
            r_outValid <= 1'b0;
        end
    end

    // Line buffers and window run in every mode so a switch to convolution starts primed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= bus.in_data;
            for (int i = 0; i < 9; i++) r_win[i] <= w_nextWin[i];
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        if (bus.reg_addr == 5'h00)      w_rdata = {6'b0, r_shadowMode};
        else if (bus.reg_addr == 5'h01) w_rdata = r_thr;
        else if (w_isKernel)            w_rdata = r_kernel[w_kIdx];
        else if (bus.reg_addr == 5'h10) w_rdata = 8'hA6;
        else if (bus.reg_addr == 5'h11) w_rdata = r_frameCnt;
        else if (bus.reg_addr == 5'h12) w_rdata = {5'b0, r_activeMode, r_outValid};
    end

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = r_outValid;
    assign bus.out_pixel  = r_outPixel;
    assign bus.frame_done = r_frameDone;
    assign bus.reg_rdata  = w_rdata;
endmodule

// File: tb/tb_pixel_stream_processor.sv
// Scoreboard bench for pixel_stream_processor on a 4x4 image, directed vectors.
module tb_pixel_stream_processor;
    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pixel_stream_processor_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

    pixel_stream_processor #(
        .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .OUT_WIDTH(OW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int pushCount = 0;
    int popCount = 0;
    int fdCount = 0;
    int cycle = 0;
    logic [31:0] expQ [$];
    logic [31:0] monExp;
    logic [7:0]  rd;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completed output transfer.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.frame_done) fdCount++;
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got 0x%08h required no output", bus.out_pixel);
                end else begin
                    monExp = expQ.pop_front();
                    popCount++;
                    checkOutput("scoreboard", bus.out_pixel, monExp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit hasExp, input logic [31:0] exp);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 required acceptance of 0x%02h", d);
        end else if (hasExp) begin
            expQ.push_back(exp);
            pushCount++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic regWrite(input logic [4:0] a, input logic [7:0] d);
        bus.reg_write_en = 1'b1;
        bus.reg_addr     = a;
        bus.reg_wdata    = d;
        @(posedge clk);
        #1;
        bus.reg_write_en = 1'b0;
    endtask

    task automatic regRead(input logic [4:0] a, output logic [7:0] d);
        bus.reg_addr = a;
        @(negedge clk);
        d = bus.reg_rdata;
        @(posedge clk);
        #1;
    endtask

    // Pixels 0..15; outputs expected only in the valid region (row>=2, col>=2).
    task automatic runConvFrame(input logic [31:0] e0, e1, e2, e3);
        logic [31:0] e;
        for (int i = 0; i < IW * IH; i++) begin
            if ((i / IW) >= 2 && (i % IW) >= 2) begin
                case (((i / IW) - 2) * 2 + ((i % IW) - 2))
                    0:       e = e0;
                    1:       e = e1;
                    2:       e = e2;
                    default: e = e3;
                endcase
                applyStimulus(8'(i), 1'b1, e);
                checkOutput("conv_latency", {31'b0, bus.out_valid}, 32'd1);
            end else begin
                applyStimulus(8'(i), 1'b0, 32'd0);
            end
        end
        checkOutput("frame_done_pulse", {31'b0, bus.frame_done}, 32'd1);
        idle(1);
        checkOutput("frame_done_clear", {31'b0, bus.frame_done}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int cStart;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.out_ready    = 1'b1;
        bus.reg_write_en = 1'b0;
        bus.reg_addr     = '0;
        bus.reg_wdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(1);

        checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_out_pixel", bus.out_pixel, 32'd0);
        checkOutput("rst_frame_done", {31'b0, bus.frame_done}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        regRead(5'h01, rd); checkOutput("rst_thr", {24'b0, rd}, 32'h80);
        regRead(5'h08, rd); checkOutput("rst_k4", {24'b0, rd}, 32'h01);
        regRead(5'h04, rd); checkOutput("rst_k0", {24'b0, rd}, 32'h00);
        regRead(5'h11, rd); checkOutput("rst_frame_cnt", {24'b0, rd}, 32'h00);
        regRead(5'h12, rd); checkOutput("rst_status", {24'b0, rd}, 32'h00);

        // Identity kernel convolution
        regWrite(5'h00, 8'd3);
        idle(2);
        regRead(5'h12, rd); checkOutput("status_mode3", {24'b0, rd}, 32'h06);
        runConvFrame(32'd5, 32'd6, 32'd9, 32'd10);
        regRead(5'h11, rd); checkOutput("frame_cnt_1", {24'b0, rd}, 32'd1);

        // All-ones kernel, then negative centre tap
        for (int a = 4; a <= 12; a++) regWrite(5'(a), 8'd1);
        runConvFrame(32'd45, 32'd54, 32'd81, 32'd90);
        for (int a = 4; a <= 12; a++) regWrite(5'(a), (a == 8) ? 8'hFF : 8'h00);
`ifdef PIXEL_PROC_SAT_EN
        runConvFrame(32'h0, 32'h0, 32'h0, 32'h0);
`else
        runConvFrame(32'hFFFFFFFB, 32'hFFFFFFFA, 32'hFFFFFFF7, 32'hFFFFFFF6);
`endif
        regRead(5'h11, rd); checkOutput("frame_cnt_3", {24'b0, rd}, 32'd3);

        // Invert frame with a mid-frame switch to threshold
        regWrite(5'h00, 8'd1);
        idle(2);
        regRead(5'h12, rd); checkOutput("status_mode1", {30'b0, rd[2:1]}, 32'd1);
        applyStimulus(8'h3C, 1'b1, 32'h000000C3);
        applyStimulus(8'h00, 1'b1, 32'h000000FF);
        regWrite(5'h00, 8'd2);
        regRead(5'h00, rd); checkOutput("shadow_mode2", {24'b0, rd}, 32'd2);
        regRead(5'h12, rd); checkOutput("active_still1", {30'b0, rd[2:1]}, 32'd1);
        for (int i = 2; i < 16; i++) begin
            d = 8'(i * 17);
            applyStimulus(d, 1'b1, {24'b0, 8'hFF - d});
        end
        regRead(5'h12, rd); checkOutput("active_mode2", {30'b0, rd[2:1]}, 32'd2);

        // Threshold frame; thr and mode rewritten mid-frame
        applyStimulus(8'h7F, 1'b1, 32'h00);
        applyStimulus(8'h80, 1'b1, 32'hFF);
        regWrite(5'h01, 8'h40);
        applyStimulus(8'h50, 1'b1, 32'hFF);
        applyStimulus(8'h3F, 1'b1, 32'h00);
        regWrite(5'h00, 8'd0);
        for (int i = 4; i < 16; i++) begin
            d = 8'(i * 16) - 8'h08;
            applyStimulus(d, 1'b1, (d >= 8'h40) ? 32'hFF : 32'h00);
        end

        // Pass-through with back-pressure
        idle(1);
        bus.out_ready = 1'b0;
        applyStimulus(8'h11, 1'b1, 32'h11);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h22;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            checkOutput("bp_hold", bus.out_pixel, 32'h11);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        applyStimulus(8'h22, 1'b1, 32'h22);
        cStart = cycle;
        for (int i = 2; i < 16; i++) applyStimulus(8'(i * 3), 1'b1, 32'(i * 3));
        checkOutput("throughput", 32'(cycle - cStart), 32'd14);

        // Mode write at col 2 takes effect only from the next frame
        applyStimulus(8'hA0, 1'b1, 32'hA0);
        applyStimulus(8'hA1, 1'b1, 32'hA1);
        regWrite(5'h00, 8'd1);
        regRead(5'h00, rd); checkOutput("shadow_mode1", {24'b0, rd}, 32'd1);
        regRead(5'h12, rd); checkOutput("active_still0", {30'b0, rd[2:1]}, 32'd0);
        for (int i = 2; i < 16; i++) applyStimulus(8'hA0 + 8'(i), 1'b1, 32'hA0 + 32'(i));
        regRead(5'h12, rd); checkOutput("active_mode1", {30'b0, rd[2:1]}, 32'd1);

        // Inverted frame interrupted by reset at row 1, col 3
        for (int i = 0; i < 6; i++) applyStimulus(8'h10 + 8'(i), 1'b1, 32'hEF - 32'(i));
        applyStimulus(8'h16, 1'b0, 32'd0);
        checkOutput("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("rst_mid_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_mid_frame_done", {31'b0, bus.frame_done}, 32'd0);
        regRead(5'h11, rd); checkOutput("rst_mid_frame_cnt", {24'b0, rd}, 32'd0);
        rstn = 1'b1;
        idle(1);
        regRead(5'h10, rd); checkOutput("id_reg", {24'b0, rd}, 32'hA6);
        for (int i = 0; i < 16; i++) applyStimulus(8'h30 + 8'(i), 1'b1, 32'h30 + 32'(i));
        checkOutput("restart_frame_done", {31'b0, bus.frame_done}, 32'd1);
        regRead(5'h11, rd); checkOutput("restart_frame_cnt", {24'b0, rd}, 32'd1);

        idle(3);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("out_count", 32'(popCount), 32'(pushCount));
        checkOutput("frame_done_count", 32'(fdCount), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/pixel_stream_processor.md
Name: pixel_stream_processor

Overview:
Second-generation streaming pixel processor. Supports four modes: pass-through, invert, threshold, and 3x3 signed convolution over internal line buffers. Uses full valid/ready back-pressure with a registered output stage. Tracks row/column position per frame. Mode changes are applied only at frame boundaries. Sits between the pixel producer and the downstream consumer and is configured over the 8-bit register bus.

Parameters:
DATA_WIDTH, 8, unsigned pixel width; legal range 1..8.
IMG_WIDTH, 32, pixels per line; minimum 3.
IMG_HEIGHT, 32, lines per frame; minimum 3.
OUT_WIDTH, 32, output word width; must be at least DATA_WIDTH+12.

Ports:
clk  in  1  clock.
rstn  in  1  reset, asynchronous, active-low.
in_valid  in  1  input pixel valid.
in_data  in  DATA_WIDTH  unsigned input pixel, raster order.
in_ready  out  1  input accept; a transfer happens when in_valid && in_ready.
out_valid  out  1  output word valid.
out_pixel  out  OUT_WIDTH  result word.
out_ready  in  1  downstream accept.
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.
reg_write_en  in  1  register write strobe.
reg_addr  in  5  register address.
reg_wdata  in  8  register write data.
reg_rdata  out  8  combinational read data.

Behaviour:
- Reset values: out_valid=0, out_pixel=0, frame_done=0, col=row=0, frame_cnt=0, active and shadow mode=0, thr=0x80, kernel=identity (k4=1, all others 0), line buffers don't-care.
- in_ready = !out_valid || out_ready, which gives a single output register with no bubble at full throughput.
- Output register:
  - Loads on an accepted input when that input produces a result.
  - Otherwise clears out_valid when out_ready && out_valid.
  - out_pixel and out_valid are held stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid in all modes.
- Position counters advance on every accepted pixel, in every mode:
  - col wraps at IMG_WIDTH-1; when col wraps, row increments.
  - At row=IMG_HEIGHT-1 and col=IMG_WIDTH-1, both counters wrap to 0 and frame_done pulses in the same cycle as the register update.
  - frame_cnt (8-bit) increments and wraps at 255.
- Mode handling:
  - Register writes go to shadow_mode.
  - Active mode takes shadow_mode when row=0 && col=0 and no pixel is accepted in that cycle, or at the frame wrap itself.
  - A mode write mid-frame therefore takes effect from the next frame.
- Mode 0, pass-through: out = zero-extend(in_data).
- Mode 1, invert: out = zero-extend(max - in_data), where max = 2^DATA_WIDTH-1.
- Mode 2, threshold: out = (in_data >= thr[DATA_WIDTH-1:0]) ? max : 0, zero-extended.
- Mode 3, convolution:
  - Two line buffers of IMG_WIDTH entries, indexed by col. On accept, lb1[col] <= lb0[col] and lb0[col] <= in_data.
  - A 3x3 window register shifts left on every accept; columns are formed from {lb1[col], lb0[col], in_data}.
  - A result is produced only when row>=2 && col>=2, i.e. valid-region only, (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame.
  - Accepts where row<2 or col<2 produce no output.
  - Window taps kN are signed 8-bit, with k0 top-left and k8 bottom-right, and k4 on the pixel at (row-1, col-1).
  - Pixels are treated as non-negative. The sum is signed, DATA_WIDTH+12 bits, then sign-extended to OUT_WIDTH.
- The window and line buffers operate in all modes, so the first frame after switching to mode 3 is correct.
- Registers, write then read:
  - 0x00: mode[1:0], read returns the shadow value.
  - 0x01: thr.
  - 0x04..0x0C: k0..k8.
  - 0x10: ID, read-only, returns 0xA6.
  - 0x11: frame_cnt, read-only.
  - 0x12: status, read-only, {5'b0, active_mode[1:0], out_valid}.
  - All other addresses read 0x00; writes to them are ignored.
- A register write in the same cycle as a pixel accept takes effect for kernel/thr on the next accept; the current accept uses the old values.
- Asserting reset mid-frame clears the counters and out_valid immediately; a pending output is discarded.

Optional Feature:
PIXEL_PROC_SAT_EN. When defined, the mode-3 result is clamped to [0, 2^DATA_WIDTH-1] and zero-extended. When undefined, the raw signed sum is sign-extended to OUT_WIDTH.

Test Plan:
1. IMG 4x4, mode 3, identity kernel, pixels 0..15, out_ready=1 -> exactly 4 outputs, 5, 6, 9, 10, each 1 cycle after the accept of pixels 10, 11, 14, 15; frame_done on pixel 15; frame_cnt=1.
2. Same frame, all k=1 -> outputs 45, 54, 81, 90. Then k4=0xFF, others 0 -> output for the first window is 0xFFFFFFFB without the macro, 0x00000000 with PIXEL_PROC_SAT_EN.
3. Mode 1, in 0x3C -> out 0x000000C3. Mode 2, thr=0x80, inputs 0x7F, 0x80 -> outputs 0x00, 0xFF.
4. Mode 0, out_ready held low 3 cycles with in_valid=1 -> in_ready=0 for those 3 cycles, out_pixel held, no pixel lost or duplicated. Release -> throughput of 1 per cycle.
5. Write mode=1 at col=2 of frame 0 -> rest of frame 0 is pass-through, frame 1 is inverted; reg 0x00 reads 1 immediately; reg 0x12 active-mode field changes at the wrap.
6. Deassert rstn at row=1, col=3 with out_valid=1 -> out_valid=0 and frame_done=0 at once; the next frame restarts at (0,0); reg 0x10 reads 0xA6.
